// File: rtl/vending_controller.sv
// rtl/vending_controller.sv - vending transaction sequencer: credit, selection, calculator strobe, vend and change payout
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   coin_valid, coin_value          coin insertion strobe and code (0=1, 1=2, 2=5, 3=10 units)
//   select_valid, select_id         product selection strobe and index
//   cancel                          refund request
//   coin_reject, insufficient       one-cycle refusal pulses
//   current_amount, product_price   operands for the change calculator, valid with calculate
//   calculate                       one-cycle calculator strobe
//   change_amount, valid_transaction  registered calculator result
//   vend_valid, vend_id             product release pulse and index
//   change_coin_valid/value/ack     change payout handshake, one coin per transfer
//   credit, busy                    accumulated credit; high outside IDLE

module vending_controller #(
    parameter logic [4:0] PRICE_0 = 5'd7,
    parameter logic [4:0] PRICE_1 = 5'd12,
    parameter logic [4:0] PRICE_2 = 5'd15,
    parameter logic [4:0] PRICE_3 = 5'd20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       select_valid,
    input  logic [1:0] select_id,
    input  logic       cancel,
    output logic       coin_reject,
    output logic       insufficient,
    output logic [4:0] current_amount,
    output logic [4:0] product_price,
    output logic       calculate,
    input  logic [4:0] change_amount,
    input  logic       valid_transaction,
    output logic       vend_valid,
    output logic [1:0] vend_id,
    output logic       change_coin_valid,
    output logic [1:0] change_coin_value,
    input  logic       change_coin_ack,
    output logic [4:0] credit,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, CALC, WAIT, CHANGE} state_t;

    state_t     state;
    state_t     state_next;

    logic [4:0] remaining;
    logic [4:0] price_q;
    logic [1:0] id_q;
    logic       is_cancel_q;

    logic [4:0] coin_units;
    logic [5:0] credit_sum;
    logic [4:0] select_price;
    logic [1:0] greedy_code;
    logic [4:0] greedy_units;

    always_comb begin
        coin_units = 5'd1;
        case (coin_value)
            2'd0: coin_units = 5'd1;
            2'd1: coin_units = 5'd2;
            2'd2: coin_units = 5'd5;
            2'd3: coin_units = 5'd10;
            default: coin_units = 5'd1;
        endcase
    end

    // Sum checked one bit wider so an overflowing coin is refused, not wrapped.
    assign credit_sum = {1'b0, credit} + {1'b0, coin_units};

    always_comb begin
        select_price = PRICE_0;
        case (select_id)
            2'd0: select_price = PRICE_0;
            2'd1: select_price = PRICE_1;
            2'd2: select_price = PRICE_2;
            2'd3: select_price = PRICE_3;
            default: select_price = PRICE_0;
        endcase
    end

    // Largest coin not exceeding what is still owed; stable while remaining is.
    always_comb begin
        greedy_code  = 2'd0;
        greedy_units = 5'd1;
        if (remaining >= 5'd10) begin
            greedy_code  = 2'd3;
            greedy_units = 5'd10;
        end else if (remaining >= 5'd5) begin
            greedy_code  = 2'd2;
            greedy_units = 5'd5;
        end else if (remaining >= 5'd2) begin
            greedy_code  = 2'd1;
            greedy_units = 5'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        calculate         = 1'b0;
        current_amount    = 5'd0;
        product_price     = 5'd0;
        change_coin_valid = 1'b0;
        change_coin_value = 2'd0;
        busy              = (state != IDLE);
        case (state)
            IDLE: begin
                // A coin in the same cycle wins over a selection, but not over cancel.
                if (cancel || (select_valid && !coin_valid)) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                calculate      = 1'b1;
                current_amount = credit;
                product_price  = price_q;
                state_next     = WAIT;
            end
            WAIT: begin
                state_next = (change_amount != 5'd0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                change_coin_valid = 1'b1;
                change_coin_value = greedy_code;
                if (change_coin_ack && (remaining == greedy_units)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit       <= 5'd0;
            remaining    <= 5'd0;
            price_q      <= 5'd0;
            id_q         <= 2'd0;
            is_cancel_q  <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            vend_valid   <= 1'b0;
            vend_id      <= 2'd0;
        end else begin
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            vend_valid   <= 1'b0;
            vend_id      <= 2'd0;
            case (state)
                IDLE: begin
                    if (coin_valid) begin
                        if (!cancel && !credit_sum[5]) begin
                            credit <= credit_sum[4:0];
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                    if (cancel) begin
                        price_q     <= 5'd0;
                        id_q        <= 2'd0;
                        is_cancel_q <= 1'b1;
                    end else if (select_valid && !coin_valid) begin
                        price_q     <= select_price;
                        id_q        <= select_id;
                        is_cancel_q <= 1'b0;
                    end
                end
                WAIT: begin
                    remaining <= change_amount;
                    credit    <= 5'd0;
                    if (valid_transaction) begin
                        vend_valid <= 1'b1;
                        vend_id    <= id_q;
                    end else if (!is_cancel_q) begin
                        insufficient <= 1'b1;
                    end
                end
                CHANGE: begin
                    if (change_coin_ack) begin
                        remaining <= remaining - greedy_units;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/vending_controller.md
# vending_controller

Transaction sequencer for the vending machine. It accumulates inserted coins into a credit register, accepts a product selection or a cancel, and drives the change calculator with one `calculate` strobe. It then reads back the calculator's result, vends the product on a valid transaction, and pays out the change coin by coin over a valid/ack handshake. It sits between the coin/keypad front end and the change calculator and coin dispenser.

## Interface
- PRICE_0, 5'd7, price of product 0 (credit units)
- PRICE_1, 5'd12, price of product 1
- PRICE_2, 5'd15, price of product 2
- PRICE_3, 5'd20, price of product 3
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- coin_valid  input  1  one-cycle coin insertion strobe
- coin_value  input  2  coin code: 0=1, 1=2, 2=5, 3=10 units
- select_valid  input  1  one-cycle product selection strobe
- select_id  input  2  selected product index
- cancel  input  1  one-cycle cancel/refund request
- coin_reject  output  1  one-cycle pulse: inserted coin refused
- insufficient  output  1  one-cycle pulse: selection refused for lack of credit
- current_amount  output  5  credit presented to calculator
- product_price  output  5  price presented to calculator (0 on cancel)
- calculate  output  1  one-cycle calculator strobe
- change_amount  input  5  calculator result (registered)
- valid_transaction  input  1  calculator result flag (registered)
- vend_valid  output  1  one-cycle product release pulse
- vend_id  output  2  product index, valid with vend_valid
- change_coin_valid  output  1  change coin offered to dispenser
- change_coin_value  output  2  coin code, same encoding as coin_value
- change_coin_ack  input  1  dispenser accepted offered coin
- credit  output  5  current accumulated credit
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, CALC, WAIT, CHANGE.
- IDLE: on coin_valid, credit += value when the sum is ≤ 31; otherwise pulse coin_reject and leave credit unchanged.
- IDLE priority: cancel > coin > select.
  - Cancel latches price 0 and goes to CALC; a coin in the same cycle is rejected.
  - A coin and a select in the same cycle: the coin is counted and the select is ignored.
- IDLE select: latch PRICE_<select_id> and select_id, then go to CALC. Zero credit is allowed.
- CALC (one cycle): calculate=1, current_amount=credit, product_price=latched price, then go to WAIT.
- WAIT (one cycle): calculator outputs are valid.
  - Load remaining change = change_amount and clear credit to 0.
  - If valid_transaction: vend_valid=1 and vend_id=latched id in the next cycle.
  - If not valid and the request was a select (not a cancel): pulse insufficient in the next cycle.
  - Next state is CHANGE if change_amount ≠ 0, else IDLE.
- CHANGE: change_coin_valid=1 with the greedy coin, i.e. the largest of 10/5/2/1 that is ≤ remaining.
  - Value stays stable until acked.
  - On ack, remaining -= coin value.
  - When remaining reaches 0, deassert valid and return to IDLE.
- Inputs other than change_coin_ack are ignored while busy. Coins inserted while busy are not counted and not rejected.
- Arithmetic is 5-bit unsigned. The credit sum is checked in 6 bits before commit; remaining never underflows because the coin is ≤ remaining.
- Reset (any state, including mid-change), effective next cycle:
  - state=IDLE; credit, remaining, and all outputs = 0.
  - Undispensed change is discarded.

## Timing
- Request accepted at edge E0. calculate is high E0–E1, the calculator registers at E1, and the controller samples at E2.
- vend_valid and insufficient are high E2–E3; the first change_coin_valid is also high from E2.
- Coin handshake: transfer on any edge where change_coin_valid && change_coin_ack. The next coin is offered in the following cycle, giving at most one coin per cycle with ack tied high.
- credit updates the cycle after coin_valid. coin_reject is high in the cycle after the offending coin.
- current_amount and product_price are meaningful only while calculate=1; they hold 0 otherwise.

## Test plan
- Coins 10, 5 (credit 15), select 1 (price 12) -> calculate with 15/12; vend_valid, vend_id=1; change coins 2, 1; credit 0; IDLE.
- Coin 5, select 3 (price 20) -> no vend; insufficient pulse; refund one coin of 5; credit 0.
- Coins 10, 5, 2, 1 (credit 18), cancel -> product_price 0; no vend, no insufficient; refund 10, 5, 2, 1.
- Credit 30, coin 2 -> coin_reject, credit 30; then coin 1 -> credit 31, no reject. Cancel and coin in the same cycle -> coin rejected, refund of 31 = 10, 10, 10, 1.
- Change of 8 with ack held low for 5 cycles -> coin code 2 (value 5) stable throughout. Then assert reset mid-CHANGE -> next cycle all outputs 0, busy=0, credit 0.
- Select 0 with credit 0 -> calculate with 0/7; insufficient pulse; no change coins; back in IDLE at E2.
